dmem_arbiter: RTL

- Shared data-memory controller downstream of N cores.
- Consumes each core's Mem_Ctrl / DAddress / Ddout.
- Produces each core's Ddin and dacq.
- Serialises requests onto one single-port synchronous data RAM using round-robin arbitration, one transaction in flight at a time.

---
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter serialising N cores onto one
// single-port synchronous RAM, one transaction in flight at a time.
module dmem_arbiter #(
    parameter  int NCORES = 4,
    parameter  int RD_LAT = 1,
    localparam int CW     = $clog2(NCORES)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*NCORES-1:0]   core_mctrl,
    input  logic [8*NCORES-1:0]   core_daddr,
    input  logic [8*NCORES-1:0]   core_ddout,
    output logic [7:0]            core_ddin,
    output logic [NCORES-1:0]     core_dacq,
    output logic [7:0]            mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    output logic [CW-1:0]         grant_id,
    output logic                  arb_busy,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0]    LAT  = 4'(RD_LAT);
    localparam logic [CW:0]   NC   = (CW+1)'(NCORES);
    localparam logic [CW-1:0] LAST = CW'(NCORES - 1);

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       pick;
    logic                found;
    logic [CW:0]         sum;
    logic [NCORES-1:0]   req;
    logic [1:0]          code_a [NCORES];
    logic [7:0]          addr_a [NCORES];
    logic [7:0]          data_a [NCORES];
    logic [2*NCORES-1:0] unused_ctrl;

    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] ddin_q;
    logic       wr_q;
    logic       ill_q;
    logic [3:0] cnt;

    // Split the flat per-core buses into indexable per-core fields.
    for (genvar gi = 0; gi < NCORES; gi++) begin : g_unpack
        assign code_a[gi]  = core_mctrl[4*gi +: 2];
        assign addr_a[gi]  = core_daddr[8*gi +: 8];
        assign data_a[gi]  = core_ddout[8*gi +: 8];
        assign req[gi]     = |core_mctrl[4*gi +: 2];
        assign unused_ctrl[2*gi +: 2] = core_mctrl[4*gi+2 +: 2];
    end

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = 0; k < NCORES; k++) begin
            sum = {1'b0, rr_ptr} + (CW+1)'(k);
            if (sum >= NC) begin
                sum = sum - NC;
            end
            if (!found && req[sum[CW-1:0]]) begin
                found = 1'b1;
                pick  = sum[CW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: reads detour through WAIT, writes go straight to ACK.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (found) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = wr_q ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant latch, read-latency counter, read capture and pointer update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            ill_q    <= 1'b0;
            cnt      <= '0;
            ddin_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        grant_id <= pick;
                        addr_q   <= addr_a[pick];
                        wdata_q  <= data_a[pick];
                        wr_q     <= code_a[pick][1];
                        ill_q    <= &code_a[pick];
                    end
                end
                S_ISSUE: begin
                    cnt <= LAT;
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        ddin_q <= mem_rdata;
                    end
                end
                S_ACK: begin
                    if (grant_id == LAST) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= grant_id + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes, completion pulse and status decoded from the state.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        err       = 1'b0;
        core_dacq = '0;
        arb_busy  = (state != S_IDLE);
        if (state == S_ISSUE) begin
            mem_re = !wr_q;
            mem_we = wr_q;
            err    = ill_q;
        end
        if (state == S_ACK) begin
            core_dacq[grant_id] = 1'b1;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign core_ddin = ddin_q;

endmodule
